// File: rtl/id_ex_decoder.sv
// RV32I instruction-decode stage: decodes the IF/ID word and registers the
// resulting control/immediate bundle into the ID/EX boundary with a valid/ready handshake.
module id_ex_decoder #(
    parameter int XLEN      = 32,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    input  logic [XLEN-1:0]      if_inst,
    input  logic [XLEN-1:0]      if_pc,
    input  logic                 ex_ready,
    input  logic                 flush,
    output logic                 id_ready,
    output logic                 ex_valid,
    output logic [XLEN-1:0]      ex_pc,
    output logic [3:0]           ex_aluop,
    output logic [1:0]           ex_alua_sel,
    output logic                 ex_alub_sel,
    output logic [XLEN-1:0]      ex_imm,
    output logic [4:0]           ex_rs1,
    output logic [4:0]           ex_rs2,
    output logic [4:0]           ex_rd,
    output logic                 ex_regwrite,
    output logic                 ex_memread,
    output logic                 ex_memwrite,
    output logic [2:0]           ex_memfunct3,
    output logic [1:0]           ex_wb_sel,
    output logic                 ex_branch,
    output logic [2:0]           ex_brfunct3,
    output logic                 ex_jal,
    output logic                 ex_jalr,
    output logic                 ex_illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    localparam logic [1:0] A_RS1  = 2'b00;
    localparam logic [1:0] A_PC   = 2'b01;
    localparam logic [1:0] A_ZERO = 2'b10;

    localparam logic       B_RS2 = 1'b0;
    localparam logic       B_IMM = 1'b1;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [6:0] F7_ZERO = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [ILL_CNT_W-1:0] ILL_MAX = '1;
    localparam logic [ILL_CNT_W-1:0] ILL_ONE = {{(ILL_CNT_W-1){1'b0}}, 1'b1};

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = if_inst[6:0];
    assign funct3 = if_inst[14:12];
    assign funct7 = if_inst[31:25];
    assign rs1    = if_inst[19:15];
    assign rs2    = if_inst[24:20];
    assign rd     = if_inst[11:7];

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign imm_i = {{(XLEN-12){if_inst[31]}}, if_inst[31:20]};
    assign imm_s = {{(XLEN-12){if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
    assign imm_b = {{(XLEN-13){if_inst[31]}}, if_inst[31], if_inst[7],
                    if_inst[30:25], if_inst[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){if_inst[31]}}, if_inst[30:12], 12'b0};
    assign imm_j = {{(XLEN-21){if_inst[31]}}, if_inst[31], if_inst[19:12],
                    if_inst[20], if_inst[30:21], 1'b0};

    logic [3:0]      d_aluop;
    logic [1:0]      d_alua_sel;
    logic            d_alub_sel;
    logic [XLEN-1:0] d_imm;
    logic            d_writes_rd;
    logic            d_regwrite;
    logic            d_memread;
    logic            d_memwrite;
    logic [1:0]      d_wb_sel;
    logic            d_branch;
    logic            d_jal;
    logic            d_jalr;
    logic            d_illegal;

    assign id_ready = !ex_valid || ex_ready;

    // Decode defaults to an ALU add of rs1/rs2; each opcode overrides what it needs
    // and flags its own field violations, then illegal words are neutralised below.
    always_comb begin
        d_aluop     = ALU_ADD;
        d_alua_sel  = A_RS1;
        d_alub_sel  = B_RS2;
        d_imm       = '0;
        d_writes_rd = 1'b0;
        d_memread   = 1'b0;
        d_memwrite  = 1'b0;
        d_wb_sel    = WB_ALU;
        d_branch    = 1'b0;
        d_jal       = 1'b0;
        d_jalr      = 1'b0;
        d_illegal   = 1'b0;
        d_regwrite  = 1'b0;

        case (opcode)
            OPC_OP: begin
                d_aluop     = {funct7[5], funct3};
                d_writes_rd = 1'b1;
                if (!((funct7 == F7_ZERO) ||
                      ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
                    d_illegal = 1'b1;
            end
            OPC_OPIMM: begin
                d_aluop     = (funct3 == 3'b101) ? {if_inst[30], 3'b101} : {1'b0, funct3};
                d_alub_sel  = B_IMM;
                d_imm       = imm_i;
                d_writes_rd = 1'b1;
                if ((funct3 == 3'b001) && (funct7 != F7_ZERO))
                    d_illegal = 1'b1;
                if ((funct3 == 3'b101) && (funct7 != F7_ZERO) && (funct7 != F7_ALT))
                    d_illegal = 1'b1;
            end
            OPC_LUI: begin
                d_alua_sel  = A_ZERO;
                d_alub_sel  = B_IMM;
                d_imm       = imm_u;
                d_writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                d_alua_sel  = A_PC;
                d_alub_sel  = B_IMM;
                d_imm       = imm_u;
                d_writes_rd = 1'b1;
            end
            OPC_LOAD: begin
                d_alub_sel  = B_IMM;
                d_imm       = imm_i;
                d_memread   = 1'b1;
                d_wb_sel    = WB_MEM;
                d_writes_rd = 1'b1;
                if ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111))
                    d_illegal = 1'b1;
            end
            OPC_STORE: begin
                d_alub_sel = B_IMM;
                d_imm      = imm_s;
                d_memwrite = 1'b1;
                if (funct3[2] || (funct3[1:0] == 2'b11))
                    d_illegal = 1'b1;
            end
            OPC_BRANCH: begin
                d_branch = 1'b1;
                d_imm    = imm_b;
                case (funct3[2:1])
                    2'b00:   d_aluop = ALU_SUB;
                    2'b10:   d_aluop = ALU_SLT;
                    2'b11:   d_aluop = ALU_SLTU;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                d_jal       = 1'b1;
                d_alua_sel  = A_PC;
                d_alub_sel  = B_IMM;
                d_imm       = imm_j;
                d_wb_sel    = WB_PC4;
                d_writes_rd = 1'b1;
            end
            OPC_JALR: begin
                d_jalr      = 1'b1;
                d_alub_sel  = B_IMM;
                d_imm       = imm_i;
                d_wb_sel    = WB_PC4;
                d_writes_rd = 1'b1;
                if (funct3 != 3'b000)
                    d_illegal = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase

        if (d_illegal) begin
            d_aluop     = ALU_ADD;
            d_writes_rd = 1'b0;
            d_memread   = 1'b0;
            d_memwrite  = 1'b0;
            d_branch    = 1'b0;
            d_jal       = 1'b0;
            d_jalr      = 1'b0;
        end

        d_regwrite = d_writes_rd && (rd != 5'd0);
    end

    // ID/EX register: flush wins and only clears valid; a load refreshes every field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_aluop     <= '0;
            ex_alua_sel  <= '0;
            ex_alub_sel  <= 1'b0;
            ex_imm       <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_memwrite  <= 1'b0;
            ex_memfunct3 <= '0;
            ex_wb_sel    <= '0;
            ex_branch    <= 1'b0;
            ex_brfunct3  <= '0;
            ex_jal       <= 1'b0;
            ex_jalr      <= 1'b0;
            ex_illegal   <= 1'b0;
            ill_count    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (id_ready) begin
            ex_valid     <= if_valid;
            ex_pc        <= if_pc;
            ex_aluop     <= d_aluop;
            ex_alua_sel  <= d_alua_sel;
            ex_alub_sel  <= d_alub_sel;
            ex_imm       <= d_imm;
            ex_rs1       <= rs1;
            ex_rs2       <= rs2;
            ex_rd        <= rd;
            ex_regwrite  <= d_regwrite;
            ex_memread   <= d_memread;
            ex_memwrite  <= d_memwrite;
            ex_memfunct3 <= funct3;
            ex_wb_sel    <= d_wb_sel;
            ex_branch    <= d_branch;
            ex_brfunct3  <= funct3;
            ex_jal       <= d_jal;
            ex_jalr      <= d_jalr;
            ex_illegal   <= d_illegal;
            if (if_valid && d_illegal && (ill_count != ILL_MAX))
                ill_count <= ill_count + ILL_ONE;
        end
    end

endmodule

// File: tb/tb_id_ex_decoder.sv
// Scoreboard bench for id_ex_decoder: directed and random instructions are predicted
// by a behavioural RV32I decode model and checked by a monitor whenever EX takes a bundle.
module tb_id_ex_decoder;

    localparam int XLEN      = 32;
    localparam int ILL_CNT_W = 8;
    localparam int ILL_SAT   = (1 << ILL_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 if_valid;
    logic [XLEN-1:0]      if_inst;
    logic [XLEN-1:0]      if_pc;
    logic                 ex_ready;
    logic                 flush;
    logic                 id_ready;
    logic                 ex_valid;
    logic [XLEN-1:0]      ex_pc;
    logic [3:0]           ex_aluop;
    logic [1:0]           ex_alua_sel;
    logic                 ex_alub_sel;
    logic [XLEN-1:0]      ex_imm;
    logic [4:0]           ex_rs1;
    logic [4:0]           ex_rs2;
    logic [4:0]           ex_rd;
    logic                 ex_regwrite;
    logic                 ex_memread;
    logic                 ex_memwrite;
    logic [2:0]           ex_memfunct3;
    logic [1:0]           ex_wb_sel;
    logic                 ex_branch;
    logic [2:0]           ex_brfunct3;
    logic                 ex_jal;
    logic                 ex_jalr;
    logic                 ex_illegal;
    logic [ILL_CNT_W-1:0] ill_count;

    always #5 clk = ~clk;

    id_ex_decoder #(.XLEN(XLEN), .ILL_CNT_W(ILL_CNT_W)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .ex_ready(ex_ready), .flush(flush), .id_ready(id_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_aluop(ex_aluop), .ex_alua_sel(ex_alua_sel),
        .ex_alub_sel(ex_alub_sel), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memfunct3(ex_memfunct3), .ex_wb_sel(ex_wb_sel),
        .ex_branch(ex_branch), .ex_brfunct3(ex_brfunct3), .ex_jal(ex_jal),
        .ex_jalr(ex_jalr), .ex_illegal(ex_illegal), .ill_count(ill_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  aluop;
        logic [1:0]  alua;
        logic        alub;
        logic [1:0]  wb;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        legal;
        logic        chk_imm;
        logic        chk_wb;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic        slot;
    int          ill_model;
    logic [31:0] pc_ctr;

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the ISA rules, one opcode at a time.
    function automatic exp_t predict(input logic [31:0] inst, input logic [31:0] pc);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       writes;
        int         imm_i, imm_s, imm_b, imm_j;
        op     = inst[6:0];
        f3     = inst[14:12];
        f7     = inst[31:25];
        imm_i  = int'($signed(inst[31:20]));
        imm_s  = int'($signed({inst[31:25], inst[11:7]}));
        imm_b  = int'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        imm_j  = int'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        e      = '0;
        writes = 1'b0;
        e.pc   = pc;
        e.rs1  = inst[19:15];
        e.rs2  = inst[24:20];
        e.rd   = inst[11:7];
        e.f3   = f3;
        e.legal = 1'b1;
        case (op)
            7'b0110011: begin
                e.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.aluop = {f7[5], f3};
                writes = 1'b1;
            end
            7'b0010011: begin
                if (f3 == 3'd1)      e.legal = (f7 == 7'h00);
                else if (f3 == 3'd5) e.legal = (f7 == 7'h00) || (f7 == 7'h20);
                e.aluop = (f3 == 3'd5) ? {inst[30], 3'd5} : {1'b0, f3};
                e.alub = 1'b1; e.imm = imm_i; e.chk_imm = 1'b1; writes = 1'b1;
            end
            7'b0110111: begin
                e.alua = 2'd2; e.alub = 1'b1; e.imm = {inst[31:12], 12'b0};
                e.chk_imm = 1'b1; writes = 1'b1;
            end
            7'b0010111: begin
                e.alua = 2'd1; e.alub = 1'b1; e.imm = {inst[31:12], 12'b0};
                e.chk_imm = 1'b1; writes = 1'b1;
            end
            7'b0000011: begin
                e.legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
                e.alub = 1'b1; e.imm = imm_i; e.chk_imm = 1'b1;
                e.mr = 1'b1; e.wb = 2'd1; writes = 1'b1;
            end
            7'b0100011: begin
                e.legal = (f3 < 3'd3);
                e.alub = 1'b1; e.imm = imm_s; e.chk_imm = 1'b1; e.mw = 1'b1;
            end
            7'b1100011: begin
                e.legal = (f3 != 3'd2) && (f3 != 3'd3);
                e.br = 1'b1; e.imm = imm_b; e.chk_imm = 1'b1;
                if (f3 < 3'd2)      e.aluop = 4'b1000;
                else if (f3 < 3'd6) e.aluop = 4'b0010;
                else                e.aluop = 4'b0011;
            end
            7'b1101111: begin
                e.jal = 1'b1; e.alua = 2'd1; e.alub = 1'b1; e.imm = imm_j;
                e.chk_imm = 1'b1; e.wb = 2'd2; writes = 1'b1;
            end
            7'b1100111: begin
                e.legal = (f3 == 3'd0);
                e.jalr = 1'b1; e.alub = 1'b1; e.imm = imm_i;
                e.chk_imm = 1'b1; e.wb = 2'd2; writes = 1'b1;
            end
            default: e.legal = 1'b0;
        endcase
        e.chk_wb = writes;
        e.rw     = writes && (e.rd != 5'd0);
        if (!e.legal) begin
            e.aluop = 4'b0000;
            e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
            e.br = 1'b0; e.jal = 1'b0; e.jalr = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] randInst();
        logic [6:0]  ops [0:8];
        logic [31:0] w;
        int          k;
        ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};
        w = $urandom();
        k = $urandom_range(0, 9);
        if (k < 9) w[6:0] = ops[k];
        k = $urandom_range(0, 3);
        if (k == 0)      w[31:25] = 7'h00;
        else if (k == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    task automatic checkOutput(input logic exp_ready);
        checkField("id_ready", {31'b0, id_ready}, {31'b0, exp_ready});
        checkField("ex_valid", {31'b0, ex_valid}, {31'b0, slot});
    endtask

    // Called at posedge+1; drives one cycle and updates the occupancy/counter model at the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic fl, input logic rdy);
        exp_t e;
        logic ready_model;
        if_valid = v;
        if_inst  = inst;
        if_pc    = pc_ctr;
        flush    = fl;
        ex_ready = rdy;
        ready_model = !slot || rdy;
        #1 checkOutput(ready_model);
        @(posedge clk);
        if (fl) begin
            slot = 1'b0;
        end else if (ready_model) begin
            slot = v;
            if (v) begin
                e = predict(inst, pc_ctr);
                if (!e.legal && ill_model < ILL_SAT) ill_model++;
                e.cnt = ill_model[7:0];
                sb.push_back(e);
            end
        end
        pc_ctr = pc_ctr + 32'd4;
        #1;
    endtask

    task automatic compareBundle(input exp_t e);
        checkField("pc", ex_pc, e.pc);
        checkField("aluop", {28'b0, ex_aluop}, {28'b0, e.aluop});
        checkField("rs1", {27'b0, ex_rs1}, {27'b0, e.rs1});
        checkField("rs2", {27'b0, ex_rs2}, {27'b0, e.rs2});
        checkField("rd", {27'b0, ex_rd}, {27'b0, e.rd});
        checkField("memfunct3", {29'b0, ex_memfunct3}, {29'b0, e.f3});
        checkField("brfunct3", {29'b0, ex_brfunct3}, {29'b0, e.f3});
        checkField("enables", {26'b0, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jal, ex_jalr},
                   {26'b0, e.rw, e.mr, e.mw, e.br, e.jal, e.jalr});
        checkField("illegal", {31'b0, ex_illegal}, {31'b0, !e.legal});
        checkField("ill_count", {24'b0, ill_count}, {24'b0, e.cnt});
        if (e.legal) begin
            checkField("alua_sel", {30'b0, ex_alua_sel}, {30'b0, e.alua});
            checkField("alub_sel", {31'b0, ex_alub_sel}, {31'b0, e.alub});
            if (e.chk_imm) checkField("imm", ex_imm, e.imm);
            if (e.chk_wb)  checkField("wb_sel", {30'b0, ex_wb_sel}, {30'b0, e.wb});
        end
    endtask

    // Monitor: a bundle leaves when EX takes it, or is dropped when flushed while held.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ex_valid && (ex_ready || flush)) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_bundle: got ex_valid=1 pc=0x%0h expected no pending bundle", ex_pc);
                end else begin
                    e = sb.pop_front();
                    if (ex_ready) compareBundle(e);
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] directed [0:5];
        logic        v, r, f;
        directed = '{32'h002081B3, 32'h402081B3, 32'h40335293,
                     32'h123450B7, 32'hFE20AE23, 32'h00000000};
        rst = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0;
        ex_ready = 1'b0; flush = 1'b0;
        slot = 1'b0; ill_model = 0; pc_ctr = 32'h0000_1000;
        #2;
        checkField("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
        checkField("reset_id_ready", {31'b0, id_ready}, 32'd1);
        checkField("reset_ill_count", {24'b0, ill_count}, 32'd0);
        checkField("reset_aluop", {28'b0, ex_aluop}, 32'd0);
        checkField("reset_imm", ex_imm, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] directed instructions");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, directed[i], 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);

        $display("[TB] stall, hold and flush");
        applyStimulus(1'b1, 32'h002081B3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, randInst(), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h40335293, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h123450B7, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hFE20AE23, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

        $display("[TB] reset during stall");
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, randInst(), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkField("midreset_ex_valid", {31'b0, ex_valid}, 32'd0);
        checkField("midreset_ill_count", {24'b0, ill_count}, 32'd0);
        checkField("midreset_enables", {26'b0, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jal, ex_jalr}, 32'd0);
        checkField("midreset_illegal", {31'b0, ex_illegal}, 32'd0);
        checkField("midreset_pc", ex_pc, 32'd0);
        checkField("midreset_id_ready", {31'b0, id_ready}, 32'd1);
        sb.delete();
        slot = 1'b0;
        ill_model = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(1'b1, 32'h002081B3, 1'b0, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 7) == 0);
            applyStimulus(v, randInst(), f, r);
        end

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkField("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
